// File: rtl/traffic_light_ctrl_nway.sv
// ---------------------------------------------------------------------------
// traffic_light_ctrl_nway
// N-way intersection signal controller. One approach holds green at a time
// and service rotates GREEN -> YELLOW -> ALLRED -> next approach's GREEN.
// Green is held for at least MIN_GREEN ticks, extended by demand on the
// active approach, and cut at MAX_GREEN when another approach is waiting.
// All durations are counted in `tick` strobes.
//
// Optional feature macro: TRAFFIC_LIGHT_CTRL_PED_EN
//   Adds a pedestrian WALK phase (all red, ped_walk=1) after the clearance
//   that follows a pedestrian request.
//
// Ports:
//   clk        in   clock
//   reset      in   synchronous, active-high reset
//   tick       in   one-cycle timing strobe; timer and transitions advance only on it
//   sense      in   [NUM_DIR] vehicle-present level per approach
//   ped_req    in   pedestrian request pulse (PED_EN only)
//   ped_walk   out  walk indication (PED_EN only)
//   lights     out  [2*NUM_DIR] lamp code per approach: 00 green, 01 yellow, 10 red
//   active_dir out  [$clog2(NUM_DIR)] approach owning the current service
//   phase      out  [2] 00 green, 01 yellow, 10 all-red, 11 walk
// ---------------------------------------------------------------------------
module traffic_light_ctrl_nway #(
  parameter int unsigned NUM_DIR     = 4,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned MIN_GREEN   = 10,
  parameter int unsigned MAX_GREEN   = 40,
  parameter int unsigned YELLOW_TIME = 3,
  parameter int unsigned ALLRED_TIME = 2,
  parameter int unsigned PED_TIME    = 6
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       tick,
  input  logic [NUM_DIR-1:0]         sense,
`ifdef TRAFFIC_LIGHT_CTRL_PED_EN
  input  logic                       ped_req,
  output logic                       ped_walk,
`endif
  output logic [2*NUM_DIR-1:0]       lights,
  output logic [$clog2(NUM_DIR)-1:0] active_dir,
  output logic [1:0]                 phase
);

  localparam int unsigned DIR_W = $clog2(NUM_DIR);
  localparam int unsigned E_W   = CNT_W + 1;

  localparam logic [1:0] PH_GREEN  = 2'b00;
  localparam logic [1:0] PH_YELLOW = 2'b01;
  localparam logic [1:0] PH_ALLRED = 2'b10;
  localparam logic [1:0] PH_WALK   = 2'b11;

  localparam logic [1:0] LAMP_GREEN  = 2'b00;
  localparam logic [1:0] LAMP_YELLOW = 2'b01;
  localparam logic [1:0] LAMP_RED    = 2'b10;

  localparam logic [E_W-1:0]   MIN_E    = E_W'(MIN_GREEN);
  localparam logic [E_W-1:0]   MAX_E    = E_W'(MAX_GREEN);
  localparam logic [E_W-1:0]   YEL_E    = E_W'(YELLOW_TIME);
  localparam logic [E_W-1:0]   AR_E     = E_W'(ALLRED_TIME);
  localparam logic [CNT_W-1:0] MAX_T    = CNT_W'(MAX_GREEN);
`ifdef TRAFFIC_LIGHT_CTRL_PED_EN
  localparam logic [E_W-1:0]   PED_E    = E_W'(PED_TIME);
`endif

  logic [1:0]       r_phase;
  logic [DIR_W-1:0] r_active_dir;
  logic [DIR_W-1:0] r_next_dir;
  logic [CNT_W-1:0] r_timer;

  logic [1:0]       w_phase_nx;
  logic [DIR_W-1:0] w_active_nx;
  logic [DIR_W-1:0] w_next_nx;
  logic [CNT_W-1:0] w_timer_nx;
  logic [E_W-1:0]   w_e;
  logic             w_other_veh;
  logic             w_other;
  logic             w_rr_found;
  logic [DIR_W-1:0] w_rr_dir;
  logic             w_enter_walk;

`ifdef TRAFFIC_LIGHT_CTRL_PED_EN
  logic             r_ped_pending;
`endif

  // Ticks elapsed in the current phase, counting the present tick
  assign w_e = {1'b0, r_timer} + E_W'(1);

  // Vehicle demand on any approach other than the active one
  assign w_other_veh = |(sense & ~(NUM_DIR'(1) << r_active_dir));

`ifdef TRAFFIC_LIGHT_CTRL_PED_EN
  assign w_other = w_other_veh | r_ped_pending;
`else
  assign w_other = w_other_veh;
`endif

  // Round-robin search for the first demanding approach after the active one
  always_comb begin
    int unsigned idx;
    w_rr_found = 1'b0;
    w_rr_dir   = r_active_dir;
    idx        = 0;
    for (int unsigned k = 1; k < NUM_DIR; k++) begin
      idx = (32'(r_active_dir) + k) % NUM_DIR;
      if (!w_rr_found && sense[idx]) begin
        w_rr_found = 1'b1;
        w_rr_dir   = DIR_W'(idx);
      end
    end
  end

  // Phase sequencing and timer update
  always_comb begin
    logic w_trans;
    w_phase_nx   = r_phase;
    w_active_nx  = r_active_dir;
    w_next_nx    = r_next_dir;
    w_timer_nx   = r_timer;
    w_enter_walk = 1'b0;
    w_trans      = 1'b0;
    if (tick) begin
      case (r_phase)
        PH_GREEN: begin
          if (w_other && ((w_e >= MIN_E && !sense[r_active_dir]) || w_e >= MAX_E)) begin
            w_trans    = 1'b1;
            w_phase_nx = PH_YELLOW;
            // Pedestrian-only demand keeps the same approach for the next green
            w_next_nx  = w_other_veh ? w_rr_dir : r_active_dir;
          end
        end
        PH_YELLOW: begin
          if (w_e == YEL_E) begin
            w_trans    = 1'b1;
            w_phase_nx = PH_ALLRED;
          end
        end
        PH_ALLRED: begin
          if (w_e == AR_E) begin
            w_trans = 1'b1;
`ifdef TRAFFIC_LIGHT_CTRL_PED_EN
            if (r_ped_pending) begin
              w_phase_nx   = PH_WALK;
              w_enter_walk = 1'b1;
            end else begin
              w_phase_nx  = PH_GREEN;
              w_active_nx = r_next_dir;
            end
`else
            w_phase_nx  = PH_GREEN;
            w_active_nx = r_next_dir;
`endif
          end
        end
`ifdef TRAFFIC_LIGHT_CTRL_PED_EN
        PH_WALK: begin
          if (w_e == PED_E) begin
            w_trans     = 1'b1;
            w_phase_nx  = PH_GREEN;
            w_active_nx = r_next_dir;
          end
        end
`endif
        default: begin
          w_trans    = 1'b1;
          w_phase_nx = PH_GREEN;
        end
      endcase

      // Saturation only matters while green rests without competing demand
      if (w_trans) begin
        w_timer_nx = '0;
      end else if (!(r_phase == PH_GREEN && r_timer >= MAX_T)) begin
        w_timer_nx = r_timer + CNT_W'(1);
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_phase      <= PH_GREEN;
      r_active_dir <= '0;
      r_next_dir   <= '0;
      r_timer      <= '0;
    end else begin
      r_phase      <= w_phase_nx;
      r_active_dir <= w_active_nx;
      r_next_dir   <= w_next_nx;
      r_timer      <= w_timer_nx;
    end
  end

`ifdef TRAFFIC_LIGHT_CTRL_PED_EN
  // Sticky pedestrian request; a request on the WALK entry cycle survives
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ped_pending <= 1'b0;
    end else begin
      r_ped_pending <= ped_req | (r_ped_pending & ~w_enter_walk);
    end
  end

  assign ped_walk = (r_phase == PH_WALK);
`endif

  // Lamp decode from registered state only
  always_comb begin
    lights = '0;
    for (int unsigned d = 0; d < NUM_DIR; d++) begin
      lights[2*d +: 2] = LAMP_RED;
      if (DIR_W'(d) == r_active_dir) begin
        if (r_phase == PH_GREEN) begin
          lights[2*d +: 2] = LAMP_GREEN;
        end else if (r_phase == PH_YELLOW) begin
          lights[2*d +: 2] = LAMP_YELLOW;
        end
      end
    end
  end

  assign active_dir = r_active_dir;
  assign phase      = r_phase;

endmodule

// File: tb/tb_traffic_light_ctrl_nway.sv
// ---------------------------------------------------------------------------
// tb_traffic_light_ctrl_nway
// Directed bench for traffic_light_ctrl_nway with NUM_DIR=4, MIN_GREEN=4,
// MAX_GREEN=8, YELLOW_TIME=2, ALLRED_TIME=1. Inputs change 1 time unit after
// the rising edge; outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_traffic_light_ctrl_nway;

  logic       clk;
  logic       reset;
  logic       tick;
  logic [3:0] sense;
  logic [7:0] lights;
  logic [1:0] active_dir;
  logic [1:0] phase;
`ifdef TRAFFIC_LIGHT_CTRL_PED_EN
  logic       ped_req;
  logic       ped_walk;
`endif

  int n_tests;
  int n_fail;

  traffic_light_ctrl_nway #(
    .NUM_DIR    (4),
    .CNT_W      (8),
    .MIN_GREEN  (4),
    .MAX_GREEN  (8),
    .YELLOW_TIME(2),
    .ALLRED_TIME(1),
    .PED_TIME   (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .sense     (sense),
`ifdef TRAFFIC_LIGHT_CTRL_PED_EN
    .ped_req   (ped_req),
    .ped_walk  (ped_walk),
`endif
    .lights    (lights),
    .active_dir(active_dir),
    .phase     (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] s);
    reset = 1'b1;
    tick  = 1'b1;
    sense = s;
    step();
    reset = 1'b0;
  endtask

  // Step once per entry and compare lights against the expected sequence
  task automatic run_seq(input string tag, input logic [7:0] exp_q[$]);
    foreach (exp_q[i]) begin
      step();
      check($sformatf("%s[%0d]", tag, i), 32'(lights), 32'(exp_q[i]));
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    tick    = 1'b0;
    sense   = '0;
`ifdef TRAFFIC_LIGHT_CTRL_PED_EN
    ped_req = 1'b0;
`endif

    // Idle intersection rests on approach 0
    do_reset(4'b0000);
    check("rst_lights", 32'(lights), 32'h A8);
    check("rst_phase", 32'(phase), 32'd0);
    check("rst_dir", 32'(active_dir), 32'd0);
`ifdef TRAFFIC_LIGHT_CTRL_PED_EN
    check("rst_walk", 32'(ped_walk), 32'd0);
`endif
    for (int i = 0; i < 50; i++) begin
      step();
      check("idle_lights", 32'(lights), 32'h A8);
      check("idle_phase", 32'(phase), 32'd0);
      check("idle_dir", 32'(active_dir), 32'd0);
    end

    // Demand on approach 2 only: min green, yellow, clearance, then green 2
    do_reset(4'b0100);
    check("min_l0", 32'(lights), 32'h A8);
    run_seq("min", '{8'hA8, 8'hA8, 8'hA8, 8'hA9, 8'hA9, 8'hAA, 8'h8A});
    check("min_dir", 32'(active_dir), 32'd2);
    check("min_phase", 32'(phase), 32'd0);

    // Approach 2 releases: search order 3,0,1 picks 3
    sense = 4'b1010;
    run_seq("rr3", '{8'h8A, 8'h8A, 8'h8A, 8'h9A, 8'h9A, 8'hAA, 8'h2A});
    check("rr3_dir", 32'(active_dir), 32'd3);
    // Approach 3 holds demand, so it is cut at MAX; wrap skips 0 and picks 1
    run_seq("wrap", '{8'h2A, 8'h2A, 8'h2A, 8'h2A, 8'h2A, 8'h2A, 8'h2A,
                      8'h6A, 8'h6A, 8'hAA, 8'hA2});
    check("wrap_dir", 32'(active_dir), 32'd1);

    // Approach 0 held busy with demand on 1: exactly 8 green ticks
    do_reset(4'b0011);
    check("max_l0", 32'(lights), 32'h A8);
    run_seq("max", '{8'hA8, 8'hA8, 8'hA8, 8'hA8, 8'hA8, 8'hA8, 8'hA8,
                     8'hA9, 8'hA9, 8'hAA, 8'hA2});
    check("max_dir", 32'(active_dir), 32'd1);
    check("max_phase", 32'(phase), 32'd0);

    // Tick freeze in the middle of yellow
    do_reset(4'b0100);
    run_seq("frz_pre", '{8'hA8, 8'hA8, 8'hA8, 8'hA9, 8'hA9});
    tick = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      check("frz_hold", 32'(lights), 32'h A9);
      check("frz_phase", 32'(phase), 32'd1);
    end
    tick = 1'b1;
    run_seq("frz_post", '{8'hAA, 8'h8A});
    check("frz_dir", 32'(active_dir), 32'd2);

    // Reset in ALLRED, then timer must restart from zero
    do_reset(4'b0100);
`ifdef TRAFFIC_LIGHT_CTRL_PED_EN
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    run_seq("ar_pre", '{8'hA8, 8'hA8, 8'hA9, 8'hA9, 8'hAA});
`else
    run_seq("ar_pre", '{8'hA8, 8'hA8, 8'hA8, 8'hA9, 8'hA9, 8'hAA});
`endif
    check("ar_phase", 32'(phase), 32'd2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("arrst_lights", 32'(lights), 32'h A8);
    check("arrst_phase", 32'(phase), 32'd0);
    check("arrst_dir", 32'(active_dir), 32'd0);
`ifdef TRAFFIC_LIGHT_CTRL_PED_EN
    check("arrst_walk", 32'(ped_walk), 32'd0);
`endif
    // Timer at 0: yellow appears after exactly MIN ticks; then the dropped
    // pedestrian request (if any) must not yield WALK
    run_seq("arrst_tmr", '{8'hA8, 8'hA8, 8'hA8, 8'hA9, 8'hA9, 8'hAA, 8'h8A});
    check("arrst_end_phase", 32'(phase), 32'd0);
    check("arrst_end_dir", 32'(active_dir), 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_light_ctrl_nway.md
Name: traffic_light_ctrl_nway

Overview:
Parametrised N-way intersection signal controller with timed phases.
- One approach is green at a time. Phase order per service: GREEN -> YELLOW -> ALLRED -> next approach's GREEN.
- Green hold is bounded by a minimum and a maximum time, and is extended by vehicle demand on the active approach.
- Durations are counted in `tick` pulses from a shared timebase prescaler.
- The block drives lamp drivers directly and reports the active approach and phase to status logic.

Parameters:
- NUM_DIR, 4: number of approaches, 2..8.
- CNT_W, 8: phase timer width. Every *_TIME value must be < 2^CNT_W.
- MIN_GREEN, 10: minimum green in ticks, >=1.
- MAX_GREEN, 40: maximum green in ticks when another approach has demand, >=MIN_GREEN.
- YELLOW_TIME, 3: yellow duration in ticks, >=1.
- ALLRED_TIME, 2: all-red clearance in ticks, >=1.
- PED_TIME, 6: walk duration in ticks. Used only with PED_EN.

Ports:
- clk, input, 1: clock.
- reset, input, 1: synchronous, active-high reset.
- tick, input, 1: one-cycle timing strobe. The timer advances only on cycles where it is high.
- sense, input, NUM_DIR: vehicle-present sensor per approach. Level, already synchronised.
- lights, output, 2*NUM_DIR: lamp code for approach d on bits [2d+1:2d]. GREEN=00, YELLOW=01, RED=10; 11 is never driven.
- active_dir, output, $clog2(NUM_DIR): approach currently owning green, yellow or the clearance that follows it.
- phase, output, 2: GREEN=00, YELLOW=01, ALLRED=10, WALK=11.

Behaviour:
- Registered state: phase, active_dir, next_dir, and timer (CNT_W bits).
- lights, active_dir and phase decode combinationally from registered state only; they never depend combinationally on inputs.
- Reset (any cycle, including mid-phase): on the next edge phase=GREEN, active_dir=0, next_dir=0, timer=0. Output then reads approach 0 GREEN, all others RED.
- Timer:
  - cleared to 0 on every phase entry;
  - incremented on a tick cycle that causes no transition;
  - saturates at MAX_GREEN.
  - tick=0 freezes the timer and all transitions.
- Definitions: e = timer+1 (ticks elapsed including the current tick). other = OR of sense over all approaches != active_dir.
- GREEN: on a tick, go to YELLOW when `other && ((e>=MIN_GREEN && !sense[active_dir]) || e>=MAX_GREEN)`.
  - With no other demand, green rests indefinitely, regardless of MAX_GREEN.
  - At the exit, next_dir is latched: the first approach with sense set, searching round-robin from active_dir+1 and wrapping modulo NUM_DIR.
- YELLOW: active approach shows YELLOW, all others RED. Exits to ALLRED on the tick where e==YELLOW_TIME.
- ALLRED: all approaches RED. On the tick where e==ALLRED_TIME, go to GREEN with active_dir=next_dir.
  - Demand that vanished during YELLOW/ALLRED does not change next_dir.
- Latency: a transition decided on tick cycle t is visible on lights at cycle t+1.
- Simultaneous events: reset overrides tick. Sense changes on a tick cycle are evaluated with that cycle's values.

Optional Feature:
- Macro: TRAFFIC_LIGHT_CTRL_PED_EN.
- Enabled:
  - Adds input `ped_req` (1) and output `ped_walk` (1).
  - A `ped_req` pulse sets a sticky `ped_pending`. `ped_pending` is OR'd into `other`.
  - Leaving GREEN only because of pedestrian demand (no vehicle demand elsewhere) latches next_dir=active_dir.
  - At ALLRED end, if ped_pending=1: enter WALK instead of GREEN.
    - WALK shows all RED with ped_walk=1 and clears ped_pending on entry.
    - WALK exits to GREEN of next_dir on the tick where e==PED_TIME.
  - ped_req during WALK sets pending for the next cycle of service.
  - Reset clears ped_pending; ped_walk=0 at reset.
- Disabled: no ped ports, WALK is never entered, and phase never reads 11.

Test Plan (NUM_DIR=4, MIN_GREEN=4, MAX_GREEN=8, YELLOW_TIME=2, ALLRED_TIME=1, tick every cycle unless stated):
- Reset, sense=0 for 50 cycles -> lights=8'hA8, phase=00, active_dir=0 throughout.
- sense=4'b0100 from reset -> 4 cycles 8'hA8, then 2 cycles 8'hA9, then 1 cycle 8'hAA, then 8'h8A with active_dir=2.
- sense=4'b0011 held -> approach 0 green for exactly 8 ticks (MAX), then yellow. next_dir=1, and lights become 8'hA2 after clearance.
- active_dir=2 green, sense=4'b1010 -> after clearance active_dir=3 (round-robin wrap order 3,0,1).
- tick held low mid-YELLOW for 20 cycles -> lights stay 8'hA9, and the remaining yellow completes once ticks resume.
- reset asserted mid-ALLRED -> next cycle lights=8'hA8, phase=00, timer=0. With PED_EN, ped_walk=0 and the pending request is dropped.
